// File: rtl/rob_complete_arbiter_pkg.sv
// Shared out-of-order core types: ROB tag width and the execution-unit
// completion packet routed to the reorder buffer.
package ooo_types;

  localparam int ROB_BITS    = 5;
  localparam int NUM_CPL_REQ = 3;

  typedef struct packed {
    logic [ROB_BITS-1:0] tag;
    logic                taken;
    logic [31:0]         target;
  } complete_pkt_t;

endpackage

// File: rtl/rob_complete_arbiter_cpl_fifo.sv
// Small per-requester completion buffer; head is visible combinationally so a
// packet written at one edge can be granted in the very next cycle.
module cpl_fifo
  import ooo_types::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              clear,
  input  logic                              push,
  input  logic                              pop,
  input  complete_pkt_t                     din,
  output complete_pkt_t                     dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count,
  output logic                              empty,
  output logic                              full
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  complete_pkt_t   r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign empty  = (r_count == '0);
  assign full   = (r_count == CW'(FIFO_DEPTH));
  assign count  = r_count;
  assign w_push = push & ~full & ~clear;
  assign w_pop  = pop & ~empty & ~clear;
  assign dout   = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= (r_wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)
        r_rd_ptr <= (r_rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/rob_complete_arbiter.sv
// Merges per-unit completion streams onto the ROB's single completion port
// with round-robin fairness; the output is driven straight from FIFO heads.
module rob_complete_arbiter
  import ooo_types::*;
#(
  parameter int NUM_REQ    = NUM_CPL_REQ,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        flush,
  input  logic          [NUM_REQ-1:0]                 req_valid,
  output logic          [NUM_REQ-1:0]                 req_ready,
  input  complete_pkt_t [NUM_REQ-1:0]                 req_pkt,
  output logic                                        complete_en,
  output logic          [ROB_BITS-1:0]                complete_tag,
  output logic                                        branch_taken,
  output logic          [31:0]                        branch_target,
  output logic          [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic          [$clog2(NUM_REQ*FIFO_DEPTH+1)-1:0] pending_count
);

  localparam int GW  = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PCW = $clog2(NUM_REQ * FIFO_DEPTH + 1);

  complete_pkt_t   w_dout  [NUM_REQ];
  logic [CW-1:0]   w_count [NUM_REQ];
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_pop;
  logic            w_any;
  logic [GW-1:0]   w_gnt_idx;
  int              w_idx;
  complete_pkt_t   w_head;
  logic [GW-1:0]   r_rr_ptr;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    // Ready is a pure function of occupancy so a full FIFO never relies on
    // a same-cycle grant to make room.
    assign req_ready[gi] = ~w_full[gi] & ~flush & rst_n;
    assign w_pop[gi]     = complete_en && (w_gnt_idx == GW'(gi));

    cpl_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .push  (req_valid[gi] & req_ready[gi]),
      .pop   (w_pop[gi]),
      .din   (req_pkt[gi]),
      .dout  (w_dout[gi]),
      .count (w_count[gi]),
      .empty (w_empty[gi]),
      .full  (w_full[gi])
    );
  end

  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (!w_any && !w_empty[w_idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = GW'(w_idx);
      end
    end
  end

  assign complete_en   = w_any & ~flush;
  assign w_head        = w_dout[w_gnt_idx];
  assign grant_id      = complete_en ? w_gnt_idx : '0;
  assign complete_tag  = complete_en ? w_head.tag : '0;
  assign branch_taken  = complete_en ? w_head.taken : 1'b0;
  assign branch_target = complete_en ? w_head.target : '0;

  always_comb begin
    pending_count = '0;
    for (int k = 0; k < NUM_REQ; k++)
      pending_count = pending_count + PCW'(w_count[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rr_ptr <= '0;
    else if (complete_en)
      r_rr_ptr <= (w_gnt_idx == GW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
  end

endmodule

// File: tb/tb_rob_complete_arbiter.sv
// Randomised and directed bench for rob_complete_arbiter, scored against a
// queue-based model of the per-unit buffers and round-robin pointer.
module tb_rob_complete_arbiter;
  import ooo_types::*;

  localparam int N = 3;
  localparam int D = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0]          req_ready;
  complete_pkt_t [N-1:0] req_pkt = '0;
  logic                  complete_en;
  logic [ROB_BITS-1:0]   complete_tag;
  logic                  branch_taken;
  logic [31:0]           branch_target;
  logic [1:0]            grant_id;
  logic [2:0]            pending_count;

  rob_complete_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_pkt(req_pkt),
    .complete_en(complete_en), .complete_tag(complete_tag),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .grant_id(grant_id), .pending_count(pending_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [1:0]    gid;
    complete_pkt_t p;
    logic [N-1:0]  rdy;
    int            pend;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          last_e;
  complete_pkt_t mq [N][$];
  int            m_rr = 0;
  complete_pkt_t tb_pkt [N];
  bit            mon_en = 0;
  int            checks = 0;
  int            failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: one expectation per cycle, compared mid-low-phase.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("out", 64'({complete_en, grant_id, complete_tag, branch_taken, branch_target}),
                64'({e.en, e.gid, e.p}));
          check("ready", 64'(req_ready), 64'(e.rdy));
          check("pending", 64'(pending_count), 64'(e.pend));
          if (complete_en)
            $display("cpl gid=%0d tag=%0d taken=%0b target=%h pend=%0d",
                     grant_id, complete_tag, branch_taken, branch_target, pending_count);
        end
      end
    end
  end

  // Drive one cycle, predict that cycle's outputs, then advance the model.
  task automatic cycle(input logic [N-1:0] v, input logic fl);
    exp_t e;
    @(negedge clk);
    req_valid = v;
    flush = fl;
    for (int i = 0; i < N; i++) req_pkt[i] = tb_pkt[i];
    e.pend = 0;
    for (int i = 0; i < N; i++) begin
      e.rdy[i] = (mq[i].size() < D) && !fl;
      e.pend += mq[i].size();
    end
    e.en = 1'b0; e.gid = '0; e.p = '0;
    if (!fl) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (!e.en && mq[idx].size() > 0) begin
          e.en = 1'b1; e.gid = 2'(idx); e.p = mq[idx][0];
        end
      end
    end
    exp_q.push_back(e);
    mon_en = 1;
    if (fl) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      if (e.en) begin
        void'(mq[e.gid].pop_front());
        m_rr = (int'(e.gid) + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (v[i] && e.rdy[i]) mq[i].push_back(tb_pkt[i]);
    end
    last_e = e;
    #3;
  endtask

  task automatic rand_pkts();
    for (int i = 0; i < N; i++) begin
      tb_pkt[i].tag    = ROB_BITS'($urandom);
      tb_pkt[i].taken  = 1'($urandom);
      tb_pkt[i].target = $urandom;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 8; i++) cycle(3'b000, 1'b0);
  endtask

  initial begin
    int        prev_g;
    logic      saw_block;
    int        bru_idx;
    logic [4:0] bru_tags [5];
    logic [4:0] bru_out [$];

    for (int i = 0; i < N; i++) tb_pkt[i] = '0;
    #1;
    check("rst_en", 64'(complete_en), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_pending", 64'(pending_count), 64'd0);
    check("rst_outs", 64'({grant_id, complete_tag, branch_taken, branch_target}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Contention: all three accepted together with rr_ptr at 0.
    tb_pkt[0] = '{tag: 5'd1, taken: 1'b0, target: 32'h0};
    tb_pkt[1] = '{tag: 5'd2, taken: 1'b1, target: 32'h100};
    tb_pkt[2] = '{tag: 5'd3, taken: 1'b0, target: 32'h0};
    cycle(3'b111, 1'b0);
    cycle(3'b000, 1'b0);
    check("cont_tag1", 64'({complete_en, complete_tag}), 64'({1'b1, 5'd1}));
    cycle(3'b000, 1'b0);
    check("cont_tag2", 64'({complete_en, complete_tag, branch_taken, branch_target}),
          64'({1'b1, 5'd2, 1'b1, 32'h100}));
    cycle(3'b000, 1'b0);
    check("cont_tag3", 64'({complete_en, complete_tag}), 64'({1'b1, 5'd3}));

    // Single ALU completion: visible the cycle after acceptance, then idle.
    tb_pkt[0] = '{tag: 5'd5, taken: 1'b0, target: 32'h0};
    cycle(3'b001, 1'b0);
    cycle(3'b000, 1'b0);
    check("single_hit", 64'({complete_en, complete_tag, grant_id}), 64'({1'b1, 5'd5, 2'd0}));
    cycle(3'b000, 1'b0);
    check("single_idle", 64'({complete_en, pending_count}), 64'd0);

    // Fairness: ALU and LSU continuously valid must alternate.
    prev_g = -1;
    for (int c = 0; c < 10; c++) begin
      rand_pkts();
      cycle(3'b101, 1'b0);
      if (complete_en) begin
        if (prev_g >= 0) check("fair_alt", 64'(grant_id == 2'(prev_g)), 64'd0);
        prev_g = int'(grant_id);
      end
    end
    drain();

    // Backpressure: BRU offers ordered tags, each held until accepted.
    bru_tags = '{5'd4, 5'd6, 5'd7, 5'd9, 5'd11};
    bru_idx = 0;
    saw_block = 1'b0;
    for (int c = 0; c < 14; c++) begin
      rand_pkts();
      tb_pkt[1].tag = (bru_idx < 5) ? bru_tags[bru_idx] : 5'd0;
      cycle({1'b0, bru_idx < 5, 1'b1}, 1'b0);
      if (bru_idx < 5 && !req_ready[1]) saw_block = 1'b1;
      if (complete_en && grant_id == 2'd1) bru_out.push_back(complete_tag);
      if (bru_idx < 5 && last_e.rdy[1]) bru_idx++;
    end
    for (int c = 0; c < 8; c++) begin
      cycle(3'b000, 1'b0);
      if (complete_en && grant_id == 2'd1) bru_out.push_back(complete_tag);
    end
    check("bp_blocked", 64'(saw_block), 64'd1);
    check("bp_count", 64'(bru_out.size()), 64'd5);
    for (int i = 0; i < 5 && i < bru_out.size(); i++)
      check("bp_order", 64'(bru_out[i]), 64'(bru_tags[i]));

    // Flush with five pending and a concurrent valid.
    rand_pkts();
    cycle(3'b111, 1'b0);
    rand_pkts();
    cycle(3'b111, 1'b0);
    rand_pkts();
    cycle(3'b111, 1'b1);
    check("flush_pend5", 64'(pending_count), 64'd5);
    check("flush_en", 64'(complete_en), 64'd0);
    check("flush_ready", 64'(req_ready), 64'd0);
    cycle(3'b000, 1'b0);
    check("flush_empty", 64'(pending_count), 64'd0);

    // Asynchronous reset mid-cycle with three pending.
    rand_pkts();
    cycle(3'b111, 1'b0);
    cycle(3'b000, 1'b0);
    check("ar_pend3", 64'(pending_count), 64'd3);
    req_valid = '0;
    rst_n = 1'b0;
    mon_en = 0;
    #1;
    check("ar_en", 64'(complete_en), 64'd0);
    check("ar_pending", 64'(pending_count), 64'd0);
    check("ar_ready", 64'(req_ready), 64'd0);
    for (int i = 0; i < N; i++) mq[i].delete();
    m_rr = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Random traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      rand_pkts();
      cycle(3'($urandom), ($urandom_range(0, 19) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_complete_arbiter.md
ROB_COMPLETE_ARBITER -- requirements
Module: rob_complete_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of execution-unit requesters (0=ALU, 1=BRU, 2=LSU).
REQ-002 Parameter FIFO_DEPTH, default 2: completion buffer entries per requester, power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  mispredict flush from ROB; discards all pending completions.
REQ-006 req_valid  input  NUM_REQ  per-requester completion valid.
REQ-007 req_ready  output  NUM_REQ  per-requester buffer can accept.
REQ-008 req_pkt  input  NUM_REQ x complete_pkt_t  per-requester {tag[ROB_BITS], taken, target[32]}.
REQ-009 complete_en  output  1  drives ROB complete_en.
REQ-010 complete_tag  output  ROB_BITS  drives ROB complete_tag.
REQ-011 branch_taken  output  1  drives ROB branch_taken.
REQ-012 branch_target  output  32  drives ROB branch_target.
REQ-013 grant_id  output  $clog2(NUM_REQ)  requester index presented this cycle; 0 when complete_en=0.
REQ-014 pending_count  output  $clog2(NUM_REQ*FIFO_DEPTH+1)  total buffered completions.

Function
REQ-015 Block SHALL serialise up to NUM_REQ completion streams onto the ROB's single completion port, one completion per cycle max.
REQ-016 Requester i SHALL enqueue req_pkt[i] at the edge where req_valid[i] && req_ready[i].
REQ-017 req_ready[i] SHALL equal (fifo_count[i] < FIFO_DEPTH) && !flush; it SHALL NOT depend on req_valid or on same-cycle dequeue (no full-FIFO bypass).
REQ-018 Minimum latency: packet accepted at edge N SHALL appear on complete_en/complete_tag in cycle N+1 (combinational from FIFO head, no output register).
REQ-019 complete_en SHALL be 1 iff any FIFO non-empty && !flush.
REQ-020 Arbitration SHALL be round-robin: scan from rr_ptr upward modulo NUM_REQ; first non-empty FIFO wins.
REQ-021 On a grant to index g, the granted FIFO SHALL dequeue its head and rr_ptr SHALL become (g+1) mod NUM_REQ at that edge; with no grant rr_ptr SHALL hold.
REQ-022 Outputs complete_tag/branch_taken/branch_target SHALL reflect the granted head; when complete_en=0 they SHALL be 0.
REQ-023 Same-cycle enqueue and dequeue on one non-full FIFO SHALL leave its count unchanged and preserve order (FIFO order per requester guaranteed; no cross-requester ordering).
REQ-024 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 flush=1: complete_en forced 0, no enqueue, no dequeue; at that edge all FIFOs SHALL empty; rr_ptr SHALL hold.
REQ-026 pending_count SHALL equal sum of FIFO counts, updated each edge.
REQ-027 Block SHALL NOT inspect tags; duplicate or stale tags pass through unchanged.

Reset
REQ-028 rst_n=0 SHALL immediately (asynchronously) empty all FIFOs, set rr_ptr=0, and hold pending_count=0.
REQ-029 During reset complete_en=0, grant_id=0, complete_tag/branch_taken/branch_target=0, req_ready all 0.
REQ-030 Reset asserted mid-operation SHALL drop all buffered completions; first accept permitted in the first cycle after rst_n rises.

Structure
REQ-031 complete_pkt_t and NUM_CPL_REQ SHALL reside in package ooo_types alongside ROB_BITS.
REQ-032 Per-requester buffering SHALL be a sub-module cpl_fifo (parameter FIFO_DEPTH, ports clk, rst_n, clear, push, pop, din, dout, count, empty, full), instantiated NUM_REQ times.
REQ-033 Arbiter and rr_ptr logic SHALL live in rob_complete_arbiter itself.

Verification
REQ-034 Single: reset, then ALU pushes tag=5 at edge 1 -> cycle 2 complete_en=1, complete_tag=5, grant_id=0; cycle 3 complete_en=0, pending_count=0.
REQ-035 Contention: ALU tag=1, BRU tag=2 (taken=1, target=0x100), LSU tag=3 all accepted same edge, rr_ptr=0 -> tags 1,2,3 on three consecutive cycles; cycle with tag 2 shows branch_taken=1, branch_target=0x100.
REQ-036 Fairness: ALU and LSU valid continuously -> grant_id alternates 0,2,0,2; no requester waits more than NUM_REQ-1 grants.
REQ-037 Backpressure: BRU pushes tags 4,6 while ALU holds grants -> BRU req_ready=0 with count=2; third push stalls until a BRU dequeue edge; order out 4,6 then third.
REQ-038 Flush: pending_count=5, flush=1 one cycle -> complete_en=0 that cycle, pending_count=0 next cycle, a concurrent req_valid not accepted.
REQ-039 Async reset: rst_n pulsed low mid-cycle with 3 pending -> complete_en and pending_count go 0 without a clock edge.
